riscv_inst_decode_queue: RTL

- Buffered front-end decode stage for the RISC-V pipeline.
- Accepts raw 32-bit instruction words with their PC over a val/rdy handshake and holds them in a DEPTH-entry queue.
- Presents the head entry fully decoded: register fields, format class, sign-extended XLEN-bit immediate, and PC-relative target.
- Sits between instruction fetch and the decode/issue stage. A flush input supports redirects.

---
 rtl/riscv_inst_decode_queue_if.sv | 47 ++++
 rtl/riscv_inst_decode_queue.sv | 134 +++++++++++++
 2 files changed

// File: rtl/riscv_inst_decode_queue_if.sv
// Fetch-to-decode bus for riscv_inst_decode_queue: raw instruction in, decoded head entry out.
// out_illegal exists only when RISCV_INST_DECODE_ILLEGAL_EN is defined.
interface riscv_inst_decode_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic            in_val;
   logic            in_rdy;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            out_val;
   logic            out_rdy;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_imm;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_target;
   logic [CW-1:0]   count;
`ifdef RISCV_INST_DECODE_ILLEGAL_EN
   logic            out_illegal;
`endif

   modport slave (
      input  in_val, in_inst, in_pc, out_rdy,
      output in_rdy, out_val, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
             out_funct7, out_fmt, out_imm, out_pc, out_target, count
`ifdef RISCV_INST_DECODE_ILLEGAL_EN
      , output out_illegal
`endif
   );

   modport master (
      output in_val, in_inst, in_pc, out_rdy,
      input  in_rdy, out_val, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
             out_funct7, out_fmt, out_imm, out_pc, out_target, count
`ifdef RISCV_INST_DECODE_ILLEGAL_EN
      , input out_illegal
`endif
   );
endinterface

// File: rtl/riscv_inst_decode_queue.sv
// DEPTH-entry instruction queue that presents its head entry fully decoded (fields, format, imm, target).
// Define RISCV_INST_DECODE_ILLEGAL_EN to add the out_illegal legality flag.
module riscv_inst_decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input logic                    clk,
   input logic                    reset,
   input logic                    flush,
   riscv_inst_decode_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_SB  = 3'd3,
      FMT_U   = 3'd4,
      FMT_UJ  = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   logic [31:0]     inst_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_r;
   logic            enq;
   logic            deq;
   logic [31:0]     head_inst;
   logic [XLEN-1:0] head_pc;
   fmt_e            fmt;
   logic signed [31:0] imm32;
   logic [XLEN-1:0] imm;

   // Handshake: a beat transfers on a cycle where val && rdy at the rising edge. in_rdy ignores
   // out_rdy (no pass-through when full) and drops while flush is high; out_val is occupancy only.
   assign q.in_rdy  = (count_r != CW'(DEPTH)) && !flush;
   assign q.out_val = (count_r != '0);
   assign enq       = q.in_val && q.in_rdy;
   assign deq       = q.out_val && q.out_rdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
      end else begin
         if (enq) begin
            inst_mem[wr_ptr] <= q.in_inst;
            pc_mem[wr_ptr]   <= q.in_pc;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         if (enq && !deq)      count_r <= count_r + CW'(1);
         else if (deq && !enq) count_r <= count_r - CW'(1);
      end
   end

   // Everything below decodes the registered head entry only.
   assign head_inst = inst_mem[rd_ptr];
   assign head_pc   = pc_mem[rd_ptr];

   always_comb begin
      fmt = FMT_ILL;
      case (head_inst[6:0])
         7'b0110011:                         fmt = FMT_R;
         7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
         7'b0100011:                         fmt = FMT_S;
         7'b1100011:                         fmt = FMT_SB;
         7'b0110111, 7'b0010111:             fmt = FMT_U;
         7'b1101111:                         fmt = FMT_UJ;
         default:                            fmt = FMT_ILL;
      endcase
   end

   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{head_inst[31]}}, head_inst[31:20]};
         FMT_S:   imm32 = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
         FMT_SB:  imm32 = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25],
                           head_inst[11:8], 1'b0};
         FMT_U:   imm32 = {head_inst[31:12], 12'b0};
         FMT_UJ:  imm32 = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20],
                           head_inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Signed size cast widens to XLEN by replicating bit 31.
   assign imm = XLEN'(imm32);

   assign q.out_opcode = head_inst[6:0];
   assign q.out_rd     = head_inst[11:7];
   assign q.out_funct3 = head_inst[14:12];
   assign q.out_rs1    = head_inst[19:15];
   assign q.out_rs2    = head_inst[24:20];
   assign q.out_funct7 = head_inst[31:25];
   assign q.out_fmt    = fmt;
   assign q.out_imm    = imm;
   assign q.out_pc     = head_pc;
   assign q.out_target = (fmt == FMT_SB || fmt == FMT_UJ) ? head_pc + imm : head_pc + XLEN'(4);
   assign q.count      = count_r;

`ifdef RISCV_INST_DECODE_ILLEGAL_EN
   logic illegal;

   always_comb begin
      illegal = 1'b0;
      case (fmt)
         FMT_ILL: illegal = 1'b1;
         FMT_R:   illegal = !(head_inst[31:25] == 7'b0000000 || head_inst[31:25] == 7'b0100000 ||
                              head_inst[31:25] == 7'b0000001);
         FMT_S:   illegal = (head_inst[14:12] > 3'b010);
         FMT_SB:  illegal = (head_inst[14:12] == 3'b010 || head_inst[14:12] == 3'b011);
         default: illegal = 1'b0;
      endcase
      if (head_inst[1:0] != 2'b11) illegal = 1'b1;
   end

   assign q.out_illegal = q.out_val && illegal;
`endif
endmodule
